// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: icodes, register IDs, status codes, writeback bundle layout and the writeback FSM states.
package y86_pkg;

    localparam int unsigned NREG = 15;
    localparam int unsigned XLEN = 64;
    localparam int unsigned RIDW = 4;
    localparam int unsigned WB_W = 145;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    // Bit positions of the writeback bundle; the memory stage packs against these.
    localparam int unsigned WB_DMEM_ERR_BIT = 144;
    localparam int unsigned WB_ICODE_LSB    = 140;
    localparam int unsigned WB_VALE_LSB     = 72;
    localparam int unsigned WB_VALM_LSB     = 8;
    localparam int unsigned WB_DSTE_LSB     = 4;
    localparam int unsigned WB_DSTM_LSB     = 0;

    typedef struct packed {
        logic            dmem_error;  // [144]
        logic [3:0]      icode;       // [143:140]
        logic [3:0]      rsvd;        // [139:136]
        logic [XLEN-1:0] valE;        // [135:72]
        logic [XLEN-1:0] valM;        // [71:8]
        logic [RIDW-1:0] dstE;        // [7:4]
        logic [RIDW-1:0] dstM;        // [3:0]
    } wb_bundle_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_FAULT  = 2'd2
    } wb_state_e;

endpackage

// File: rtl/writeback_regfile_if.sv
// Writeback-stage bus: memory bundle in, decode read ports, W_* forwarding and status out.
// Optional retired_cnt present when WB_RETIRE_CNT_EN is defined.
interface writeback_regfile_if;
    import y86_pkg::*;

    wb_bundle_t      writeback_reg;
    logic [3:0]      d_srcA;
    logic [3:0]      d_srcB;
    logic [XLEN-1:0] d_rvalA;
    logic [XLEN-1:0] d_rvalB;
    logic [3:0]      W_icode;
    logic [3:0]      W_dstE;
    logic [XLEN-1:0] W_valE;
    logic [3:0]      W_dstM;
    logic [XLEN-1:0] W_valM;
    logic [2:0]      stat;
    logic            cpu_halt;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0]     retired_cnt;
`endif

    modport master (
`ifdef WB_RETIRE_CNT_EN
        input  retired_cnt,
`endif
        output writeback_reg, d_srcA, d_srcB,
        input  d_rvalA, d_rvalB, W_icode, W_dstE, W_valE, W_dstM, W_valM, stat, cpu_halt
    );

    modport slave (
`ifdef WB_RETIRE_CNT_EN
        output retired_cnt,
`endif
        input  writeback_reg, d_srcA, d_srcB,
        output d_rvalA, d_rvalB, W_icode, W_dstE, W_valE, W_dstM, W_valM, stat, cpu_halt
    );

endinterface

// File: rtl/y86_regfile.sv
// 15 x 64 architectural register file: two async read ports (ID 15 reads 0), two write ports with M over E.
module y86_regfile
    import y86_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            we_e_i,
    input  logic [3:0]      dst_e_i,
    input  logic [XLEN-1:0] val_e_i,
    input  logic            we_m_i,
    input  logic [3:0]      dst_m_i,
    input  logic [XLEN-1:0] val_m_i,
    input  logic [3:0]      src_a_i,
    input  logic [3:0]      src_b_i,
    output logic [XLEN-1:0] rdata_a_o,
    output logic [XLEN-1:0] rdata_b_o
);

    logic [XLEN-1:0] regs_q [NREG];

    // Same-ID double write keeps valM (popq %rsp).
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NREG); i++) begin
                if (we_m_i && (dst_m_i == 4'(i))) begin
                    regs_q[i] <= val_m_i;
                end else if (we_e_i && (dst_e_i == 4'(i))) begin
                    regs_q[i] <= val_e_i;
                end
            end
        end
    end

    assign rdata_a_o = (src_a_i == RNONE) ? '0 : regs_q[src_a_i];
    assign rdata_b_o = (src_b_i == RNONE) ? '0 : regs_q[src_b_i];

endmodule

// File: rtl/writeback_regfile.sv
// Y86-64 writeback stage: commits valE/valM, drives W_* forwarding, tracks stat and freezes on halt/fault.
// Define WB_RETIRE_CNT_EN to add the retired-instruction counter.
module writeback_regfile
    import y86_pkg::*;
(
    input  logic clk,
    input  logic reset,
    writeback_regfile_if.slave wb_if
);

    wb_bundle_t      bundle_c;
    wb_state_e       state_q;
    logic            run_c;
    logic            fault_c;
    logic            halt_c;
    logic            commit_c;
    logic            we_e_c;
    logic            we_m_c;
    logic [2:0]      fault_stat_c;
    logic            unused_rsvd_c;

    logic [3:0]      w_icode_q;
    logic [3:0]      w_dste_q;
    logic [3:0]      w_dstm_q;
    logic [XLEN-1:0] w_vale_q;
    logic [XLEN-1:0] w_valm_q;
    logic [2:0]      stat_q;
    logic            cpu_halt_q;

    assign bundle_c      = wb_if.writeback_reg;
    assign unused_rsvd_c = ^bundle_c.rsvd;

    // Classify the incoming bundle; writes only happen for a clean commit in RUN.
    always_comb begin
        run_c        = (state_q == ST_RUN);
        fault_c      = bundle_c.dmem_error || (bundle_c.icode > IPOPQ);
        fault_stat_c = bundle_c.dmem_error ? SADR : SINS;
        halt_c       = !fault_c && (bundle_c.icode == IHALT);
        commit_c     = run_c && !fault_c && !halt_c;
        we_e_c       = commit_c && (bundle_c.dstE != RNONE);
        we_m_c       = commit_c && (bundle_c.dstM != RNONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            stat_q     <= SAOK;
            cpu_halt_q <= 1'b0;
            w_icode_q  <= INOP;
            w_dste_q   <= RNONE;
            w_dstm_q   <= RNONE;
            w_vale_q   <= '0;
            w_valm_q   <= '0;
        end else if (run_c) begin
            w_icode_q <= bundle_c.icode;
            w_vale_q  <= bundle_c.valE;
            w_valm_q  <= bundle_c.valM;
            if (fault_c) begin
                state_q    <= ST_FAULT;
                stat_q     <= fault_stat_c;
                cpu_halt_q <= 1'b1;
                w_dste_q   <= RNONE;
                w_dstm_q   <= RNONE;
            end else if (halt_c) begin
                state_q    <= ST_HALTED;
                stat_q     <= SHLT;
                cpu_halt_q <= 1'b1;
                w_dste_q   <= RNONE;
                w_dstm_q   <= RNONE;
            end else begin
                w_dste_q <= bundle_c.dstE;
                w_dstm_q <= bundle_c.dstM;
            end
        end
    end

    y86_regfile u_regfile (
        .clk       (clk),
        .reset     (reset),
        .we_e_i    (we_e_c),
        .dst_e_i   (bundle_c.dstE),
        .val_e_i   (bundle_c.valE),
        .we_m_i    (we_m_c),
        .dst_m_i   (bundle_c.dstM),
        .val_m_i   (bundle_c.valM),
        .src_a_i   (wb_if.d_srcA),
        .src_b_i   (wb_if.d_srcB),
        .rdata_a_o (wb_if.d_rvalA),
        .rdata_b_o (wb_if.d_rvalB)
    );

    assign wb_if.W_icode  = w_icode_q;
    assign wb_if.W_dstE   = w_dste_q;
    assign wb_if.W_dstM   = w_dstm_q;
    assign wb_if.W_valE   = w_vale_q;
    assign wb_if.W_valM   = w_valm_q;
    assign wb_if.stat     = stat_q;
    assign wb_if.cpu_halt = cpu_halt_q;

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retired_cnt_q;

    // Counts real instructions only; nops/bubbles are not retirements.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_cnt_q <= '0;
        end else if (commit_c && (bundle_c.icode != INOP)) begin
            retired_cnt_q <= retired_cnt_q + 64'd1;
        end
    end

    assign wb_if.retired_cnt = retired_cnt_q;
`endif

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed vector bench for writeback_regfile; exercises retired_cnt when WB_RETIRE_CNT_EN is defined.
module tb_writeback_regfile;
    import y86_pkg::*;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    writeback_regfile_if wb_if ();

    writeback_regfile u_dut (
        .clk   (clk),
        .reset (reset),
        .wb_if (wb_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        err;
        logic [3:0]  ic;
        logic [63:0] ve;
        logic [63:0] vm;
        logic [3:0]  de;
        logic [3:0]  dm;
        logic [3:0]  sa;
        logic [3:0]  sb;
        logic [63:0] ea;
        logic [63:0] eb;
        logic [3:0]  eic;
        logic [3:0]  ede;
        logic [3:0]  edm;
        logic [63:0] eve;
        logic [63:0] evm;
        logic [2:0]  est;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    function automatic vec_t mkv(logic rst, logic err, logic [3:0] ic, logic [63:0] ve, logic [63:0] vm,
                                 logic [3:0] de, logic [3:0] dm, logic [3:0] sa, logic [3:0] sb,
                                 logic [63:0] ea, logic [63:0] eb, logic [3:0] eic, logic [3:0] ede,
                                 logic [3:0] edm, logic [63:0] eve, logic [63:0] evm, logic [2:0] est);
        vec_t v;
        v.rst = rst; v.err = err; v.ic = ic; v.ve = ve; v.vm = vm; v.de = de; v.dm = dm;
        v.sa = sa; v.sb = sb; v.ea = ea; v.eb = eb; v.eic = eic; v.ede = ede; v.edm = edm;
        v.eve = eve; v.evm = evm; v.est = est;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic err, input logic [3:0] ic, input logic [63:0] ve,
                         input logic [63:0] vm, input logic [3:0] de, input logic [3:0] dm,
                         input logic [3:0] sa, input logic [3:0] sb);
        wb_bundle_t b;
        b.dmem_error = err; b.icode = ic; b.rsvd = 4'h0; b.valE = ve; b.valM = vm; b.dstE = de; b.dstM = dm;
        reset = rst;
        wb_if.writeback_reg = b;
        wb_if.d_srcA = sa;
        wb_if.d_srcB = sb;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        drive(1'b1, 1'b0, INOP, 64'h0, 64'h0, RNONE, RNONE, RNONE, RNONE);

        //        rst  err  ic  valE                   valM     dstE  dstM  sA    sB    expA                   expB     W_ic W_dE W_dM W_valE                 W_valM   stat
        vecs[0]  = mkv(1, 0, 3,  64'h55,                64'h0,   4'd2, RNONE, 4'd2, RNONE, 64'h0,                64'h0,   1,  15, 15, 64'h0,                64'h0,   SAOK);
        vecs[1]  = mkv(0, 0, 3,  64'h1234,              64'h0,   4'd2, RNONE, 4'd2, RNONE, 64'h1234,             64'h0,   3,   2, 15, 64'h1234,             64'h0,   SAOK);
        vecs[2]  = mkv(0, 0, 11, 64'h100,               64'hBEEF,4'd4, 4'd4,  4'd4, 4'd2,  64'hBEEF,             64'h1234,11,   4,  4, 64'h100,              64'hBEEF,SAOK);
        vecs[3]  = mkv(0, 0, 1,  64'hAA,                64'h0,   RNONE,RNONE, 4'd4, 4'd2,  64'hBEEF,             64'h1234, 1,  15, 15, 64'hAA,               64'h0,   SAOK);
        vecs[4]  = mkv(0, 0, 6,  64'h77,                64'h88,  4'd3, 4'd5,  4'd3, 4'd5,  64'h77,               64'h88,   6,   3,  5, 64'h77,               64'h88,  SAOK);
        vecs[5]  = mkv(0, 1, 5,  64'h11,                64'h55,  RNONE,4'd3,  4'd3, RNONE, 64'h77,               64'h0,    5,  15, 15, 64'h11,               64'h55,  SADR);
        vecs[6]  = mkv(0, 0, 2,  64'h99,                64'h99,  4'd3, 4'd3,  4'd3, 4'd5,  64'h77,               64'h88,   5,  15, 15, 64'h11,               64'h55,  SADR);
        vecs[7]  = mkv(1, 0, 2,  64'h99,                64'h0,   4'd3, RNONE, 4'd3, 4'd4,  64'h0,                64'h0,    1,  15, 15, 64'h0,                64'h0,   SAOK);
        vecs[8]  = mkv(0, 0, 0,  64'h5,                 64'h0,   RNONE,RNONE, 4'd1, RNONE, 64'h0,                64'h0,    0,  15, 15, 64'h5,                64'h0,   SHLT);
        vecs[9]  = mkv(0, 0, 3,  64'h7,                 64'h0,   4'd1, RNONE, 4'd1, RNONE, 64'h0,                64'h0,    0,  15, 15, 64'h5,                64'h0,   SHLT);
        vecs[10] = mkv(1, 0, 3,  64'h7,                 64'h0,   4'd1, RNONE, 4'd1, RNONE, 64'h0,                64'h0,    1,  15, 15, 64'h0,                64'h0,   SAOK);
        vecs[11] = mkv(0, 0, 12, 64'h42,                64'h0,   4'd6, RNONE, 4'd6, RNONE, 64'h0,                64'h0,   12,  15, 15, 64'h42,               64'h0,   SINS);
        vecs[12] = mkv(0, 0, 7,  64'h1,                 64'h0,   4'd6, RNONE, 4'd6, RNONE, 64'h0,                64'h0,   12,  15, 15, 64'h42,               64'h0,   SINS);
        vecs[13] = mkv(1, 0, 1,  64'h0,                 64'h0,   RNONE,RNONE, 4'd6, RNONE, 64'h0,                64'h0,    1,  15, 15, 64'h0,                64'h0,   SAOK);
        vecs[14] = mkv(0, 0, 2,  64'hFFFF_FFFF_FFFF_FFFF,64'h1,  4'd14,4'd0,  4'd14,4'd0,  64'hFFFF_FFFF_FFFF_FFFF,64'h1,  2,  14,  0, 64'hFFFF_FFFF_FFFF_FFFF,64'h1,  SAOK);
        vecs[15] = mkv(0, 0, 10, 64'hA,                 64'hB,   4'd7, 4'd7,  4'd7, RNONE, 64'hB,                64'h0,   10,   7,  7, 64'hA,                64'hB,   SAOK);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].err, vecs[i].ic, vecs[i].ve, vecs[i].vm,
                  vecs[i].de, vecs[i].dm, vecs[i].sa, vecs[i].sb);
            @(posedge clk);
            #1;
            check($sformatf("v%0d d_rvalA", i), wb_if.d_rvalA, vecs[i].ea);
            check($sformatf("v%0d d_rvalB", i), wb_if.d_rvalB, vecs[i].eb);
            check($sformatf("v%0d W_icode", i), 64'(wb_if.W_icode), 64'(vecs[i].eic));
            check($sformatf("v%0d W_dstE", i), 64'(wb_if.W_dstE), 64'(vecs[i].ede));
            check($sformatf("v%0d W_dstM", i), 64'(wb_if.W_dstM), 64'(vecs[i].edm));
            check($sformatf("v%0d W_valE", i), wb_if.W_valE, vecs[i].eve);
            check($sformatf("v%0d W_valM", i), wb_if.W_valM, vecs[i].evm);
            check($sformatf("v%0d stat", i), 64'(wb_if.stat), 64'(vecs[i].est));
            check($sformatf("v%0d cpu_halt", i), 64'(wb_if.cpu_halt), 64'(vecs[i].est != SAOK));
        end

        // Read port shows the old value until the sampling edge, new value after it.
        @(negedge clk);
        drive(1'b0, 1'b0, IIRMOVQ, 64'h808, 64'h0, 4'd8, RNONE, 4'd8, 4'd7);
        #1;
        check("latency pre-edge r8", wb_if.d_rvalA, 64'h0);
        @(posedge clk);
        #1;
        check("latency post-edge r8", wb_if.d_rvalA, 64'h808);
        check("latency r7 kept", wb_if.d_rvalB, 64'hB);

`ifdef WB_RETIRE_CNT_EN
        @(negedge clk);
        drive(1'b1, 1'b0, INOP, 64'h0, 64'h0, RNONE, RNONE, RNONE, RNONE);
        @(posedge clk);
        #1;
        check("retired_cnt reset", wb_if.retired_cnt, 64'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, IOPQ, 64'(k + 1), 64'h0, 4'd9, RNONE, 4'd9, RNONE);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, INOP, 64'h0, 64'h0, RNONE, RNONE, RNONE, RNONE);
        @(negedge clk);
        drive(1'b0, 1'b0, IHALT, 64'h0, 64'h0, RNONE, RNONE, 4'd9, RNONE);
        @(negedge clk);
        drive(1'b0, 1'b0, IOPQ, 64'h77, 64'h0, 4'd9, RNONE, 4'd9, RNONE);
        @(posedge clk);
        #1;
        check("retired_cnt after halt", wb_if.retired_cnt, 64'd3);
        check("retire r9 frozen", wb_if.d_rvalA, 64'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
